// File: rtl/qsn_shift_sched_len51.sv
// qsn_shift_sched_len51: column sequencer and select generator for the
// 51-wide, 3-bit QSN cyclic shifter of the layered LDPC decoder.
// Holds a per-layer table of circulant shift factors, accepts one beat per
// block column, drives left/right/merge selects and tracks each beat
// through the QSN pipeline.
// Optional feature macro: QSN_SHIFT_OFFSET_EN (adds shift_offset input that
// is added modulo P to every table entry of the layer).
module qsn_shift_sched_len51 #(
  parameter int P       = 51,
  parameter int SEL_W   = 6,
  parameter int COL_MAX = 8,
  parameter int QSN_LAT = 2
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [SEL_W-1:0] cfg_shift,
  output logic             cfg_err,
  input  logic [3:0]       col_num,
  input  logic             layer_start,
`ifdef QSN_SHIFT_OFFSET_EN
  input  logic [SEL_W-1:0] shift_offset,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SEL_W-1:0] left_sel,
  output logic [SEL_W-1:0] right_sel,
  output logic [P-2:0]     merge_sel,
  output logic             qsn_in_valid,
  output logic             out_valid,
  output logic [2:0]       out_col,
  output logic             busy,
  output logic             layer_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [SEL_W-1:0] P_S       = SEL_W'(P);
  localparam logic [3:0]       COL_MAX_C = 4'(COL_MAX);

  logic [1:0]       state_q, state_d;
  logic [3:0]       col_num_q, col_num_d;
  logic [3:0]       col_cnt_q, col_cnt_d;
  logic [SEL_W-1:0] table_q [COL_MAX];
  logic [SEL_W-1:0] table_d [COL_MAX];
  logic [SEL_W-1:0] left_q, left_d;
  logic [SEL_W-1:0] right_q, right_d;
  logic [P-2:0]     merge_q, merge_d;
  logic             qiv_q, qiv_d;
  logic [2:0]       qcol_q, qcol_d;
  logic [QSN_LAT-1:0] vpipe_q, vpipe_d;
  logic [2:0]       cpipe_q [QSN_LAT];
  logic [2:0]       cpipe_d [QSN_LAT];
  logic             cfg_err_q, cfg_err_d;
  logic             done_q, done_d;
`ifdef QSN_SHIFT_OFFSET_EN
  logic [SEL_W-1:0] offset_q, offset_d;
  logic [SEL_W:0]   s_sum;
`endif

  logic             accept;
  logic             line_busy;
  logic [SEL_W-1:0] s_eff;
  logic [SEL_W-1:0] thr;

  assign accept       = (state_q == ST_RUN) && in_valid;
  assign in_ready     = (state_q == ST_RUN);
  assign busy         = (state_q != ST_IDLE);
  assign cfg_err      = cfg_err_q;
  assign layer_done   = done_q;
  assign left_sel     = left_q;
  assign right_sel    = right_q;
  assign merge_sel    = merge_q;
  assign qsn_in_valid = qiv_q;
  assign out_valid    = vpipe_q[QSN_LAT-1];
  assign out_col      = cpipe_q[QSN_LAT-1];

  // Control FSM, table writes and error reporting
  always_comb begin
    state_d   = state_q;
    col_num_d = col_num_q;
    col_cnt_d = col_cnt_q;
    table_d   = table_q;
    cfg_err_d = 1'b0;
    done_d    = 1'b0;
`ifdef QSN_SHIFT_OFFSET_EN
    offset_d  = offset_q;
`endif
    if (cfg_we) begin
      if ((state_q == ST_IDLE) && (cfg_shift < P_S)) begin
        table_d[cfg_addr] = cfg_shift;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (layer_start) begin
          if ((col_num == 4'd0) || (col_num > COL_MAX_C)) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d   = ST_RUN;
            col_num_d = col_num;
            col_cnt_d = '0;
`ifdef QSN_SHIFT_OFFSET_EN
            if (shift_offset >= P_S) begin
              offset_d  = '0;
              cfg_err_d = 1'b1;
            end else begin
              offset_d = shift_offset;
            end
`endif
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          col_cnt_d = col_cnt_q + 4'd1;
          if (col_cnt_q == (col_num_q - 4'd1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Looks one cycle ahead so layer_done lines up with the cycle
        // right after the final out_valid.
        if (!line_busy) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Select encoding for the accepted beat; selects hold otherwise
  always_comb begin
`ifdef QSN_SHIFT_OFFSET_EN
    s_sum = {1'b0, table_q[col_cnt_q[2:0]]} + {1'b0, offset_q};
    s_eff = (s_sum >= {1'b0, P_S}) ? SEL_W'(s_sum - {1'b0, P_S})
                                   : s_sum[SEL_W-1:0];
`else
    s_eff = table_q[col_cnt_q[2:0]];
`endif
    thr     = P_S - SEL_W'(1) - s_eff;
    left_d  = left_q;
    right_d = right_q;
    merge_d = merge_q;
    if (accept) begin
      left_d  = s_eff;
      right_d = (s_eff == '0) ? '0 : (P_S - s_eff);
      for (int unsigned k = 0; k < P - 1; k++) begin
        merge_d[k] = (SEL_W'(k) >= thr);
      end
    end
  end

  // Valid/column delay line tracking beats through the QSN
  always_comb begin
    qiv_d      = accept;
    qcol_d     = accept ? col_cnt_q[2:0] : qcol_q;
    vpipe_d    = vpipe_q;
    cpipe_d    = cpipe_q;
    vpipe_d[0] = qiv_q;
    cpipe_d[0] = qcol_q;
    for (int unsigned i = 1; i < QSN_LAT; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
      cpipe_d[i] = cpipe_q[i-1];
    end
    line_busy = qiv_q;
    for (int unsigned i = 0; i + 1 < QSN_LAT; i++) begin
      line_busy = line_busy | vpipe_q[i];
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      col_num_q <= '0;
      col_cnt_q <= '0;
      for (int unsigned i = 0; i < COL_MAX; i++) table_q[i] <= '0;
      left_q    <= '0;
      right_q   <= '0;
      merge_q   <= '0;
      qiv_q     <= 1'b0;
      qcol_q    <= '0;
      vpipe_q   <= '0;
      for (int unsigned i = 0; i < QSN_LAT; i++) cpipe_q[i] <= '0;
      cfg_err_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef QSN_SHIFT_OFFSET_EN
      offset_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      col_num_q <= col_num_d;
      col_cnt_q <= col_cnt_d;
      table_q   <= table_d;
      left_q    <= left_d;
      right_q   <= right_d;
      merge_q   <= merge_d;
      qiv_q     <= qiv_d;
      qcol_q    <= qcol_d;
      vpipe_q   <= vpipe_d;
      cpipe_q   <= cpipe_d;
      cfg_err_q <= cfg_err_d;
      done_q    <= done_d;
`ifdef QSN_SHIFT_OFFSET_EN
      offset_q  <= offset_d;
`endif
    end
  end

endmodule
